// File: rtl/countdown_if.sv
// Menu-FSM / countdown-scheduler handshake bundle: control requests in,
// display bus plus status back out.
interface countdown_if;
  logic       start;
  logic [7:0] load_bcd;
  logic       cancel;
  logic       pause;
  logic       ack;
  logic [8:0] seconds;
  logic       busy;
  logic       timeout;

  modport master (
    output start, load_bcd, cancel, pause, ack,
    input  seconds, busy, timeout
  );

  modport slave (
    input  start, load_bcd, cancel, pause, ack,
    output seconds, busy, timeout
  );
endinterface

// File: rtl/countdown_scheduler.sv
// Two-digit BCD countdown with an internal one-second prescaler.
// It supports pause, cancel and restart, and owns the display's seconds bus.
module countdown_scheduler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  countdown_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      count_q, count_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [8:0]      seconds_q, seconds_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  // Clamp each BCD nibble to 9 so the display never receives a non-decimal digit.
  function automatic logic [7:0] sanitize_bcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {tens, ones};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) begin
      return {v[7:4], v[3:0] - 4'd1};
    end else begin
      return {v[7:4] - 4'd1, 4'd9};
    end
  endfunction

  // Next-state, count and prescaler logic; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;

    if (bus.cancel) begin
      state_d = IDLE;
      count_d = 8'h00;
      presc_d = '0;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = sanitize_bcd(bus.load_bcd);
      presc_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (count_q == 8'h00) begin
            // A zero load expires on the next edge without waiting for a tick.
            state_d = DONE;
            presc_d = '0;
          end else if (bus.pause) begin
            presc_d = presc_q;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = bcd_dec(count_q);
            if (count_q == 8'h01) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        DONE: begin
          presc_d = '0;
          if (bus.ack) begin
            state_d = IDLE;
            count_d = 8'h00;
          end else begin
            state_d = DONE;
          end
        end
        IDLE: begin
          presc_d = '0;
        end
        default: begin
          state_d = IDLE;
          count_d = 8'h00;
          presc_d = '0;
        end
      endcase
    end

    case (state_d)
      RUN:     seconds_d = {1'b1, count_d};
      DONE:    seconds_d = 9'h100;
      default: seconds_d = 9'h000;
    endcase
    busy_d    = (state_d == RUN);
    timeout_d = (state_d == DONE) && (state_q != DONE);
  end

  // State, count, prescaler and registered output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 8'h00;
      presc_q   <= '0;
      seconds_q <= 9'h000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      seconds_q <= seconds_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.seconds = seconds_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler with TICK_DIV=4: a vector table for
// single-cycle behaviour plus hand-written multi-cycle sequences.
module tb_countdown_scheduler;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  countdown_if cd ();

  countdown_scheduler #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cd.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] load;
    logic       cancel;
    logic       pause;
    logic       ack;
    logic [8:0] exp_seconds;
    logic       exp_busy;
    logic       exp_timeout;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic [7:0] l, input logic c,
                              input logic p, input logic a, input logic [8:0] es,
                              input logic eb, input logic et, input string n);
    vec_t v;
    v.start = s; v.load = l; v.cancel = c; v.pause = p; v.ack = a;
    v.exp_seconds = es; v.exp_busy = eb; v.exp_timeout = et; v.name = n;
    vecs.push_back(v);
  endfunction

  function automatic logic [8:0] disp(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {1'b1, t, o};
  endfunction

  task automatic check(input string name, input logic [8:0] es, input logic eb, input logic et);
    tests++;
    if (cd.seconds !== es || cd.busy !== eb || cd.timeout !== et) begin
      fails++;
      $display("FAIL %s: got seconds=%h busy=%b timeout=%b, want seconds=%h busy=%b timeout=%b",
               name, cd.seconds, cd.busy, cd.timeout, es, eb, et);
    end
  endtask

  // Apply inputs for one clock edge, then settle 1 time unit past the edge.
  task automatic cyc(input logic s, input logic [7:0] l, input logic c,
                     input logic p, input logic a);
    cd.start = s; cd.load_bcd = l; cd.cancel = c; cd.pause = p; cd.ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    cd.start = 1'b0; cd.load_bcd = 8'h00; cd.cancel = 1'b0; cd.pause = 1'b0; cd.ack = 1'b0;

    // Idle with ack/pause toggling
    for (int i = 0; i < 20; i++)
      add(1'b0, 8'h00, 1'b0, 1'(i % 2), 1'(i % 3 == 0), 9'h000, 1'b0, 1'b0, "idle");
    // Saturated loads
    add(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 9'h193, 1'b1, 1'b0, "load_a3");
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, "cancel_a3");
    add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 9'h199, 1'b1, 1'b0, "load_ff");
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, "cancel_ff");
    // Zero load: timeout two edges after start
    add(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0, "load_00");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h100, 1'b0, 1'b1, "zero_done");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h100, 1'b0, 1'b0, "zero_hold");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0, "zero_ack");
    // Cancel beats start
    add(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, "cancel_start");
    // Start in DONE reloads, then the first tick decrements
    add(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 9'h100, 1'b1, 1'b0, "load_00b");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h100, 1'b0, 1'b1, "done_b");
    add(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 9'h134, 1'b1, 1'b0, "restart_done");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h134, 1'b1, 1'b0, "run_p1");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h134, 1'b1, 1'b0, "run_p2");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h134, 1'b1, 1'b0, "run_p3");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 9'h133, 1'b1, 1'b0, "first_tick");
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 9'h133, 1'b1, 1'b0, "ack_in_run");
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, "cancel_run");

    // Reset state
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset", 9'h000, 1'b0, 1'b0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].start, vecs[i].load, vecs[i].cancel, vecs[i].pause, vecs[i].ack);
      check(vecs[i].name, vecs[i].exp_seconds, vecs[i].exp_busy, vecs[i].exp_timeout);
    end

    // Full countdown from 12: each value held 4 cycles, DONE after 48 edges
    cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    check("cnt12_load", 9'h112, 1'b1, 1'b0);
    for (int c = 1; c <= 47; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("cnt12_run", disp(12 - c / 4), 1'b1, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("cnt12_timeout", 9'h100, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("cnt12_done", 9'h100, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("cnt12_ack", 9'h000, 1'b0, 1'b0);

    // Pause for 7 cycles during a count of 02: expiry at edge 15
    cyc(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    check("pause_load", 9'h102, 1'b1, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'(c >= 4 && c <= 10), 1'b0);
      if (c <= 10)      check("pause_frozen", 9'h102, 1'b1, 1'b0);
      else if (c <= 14) check("pause_01", 9'h101, 1'b1, 1'b0);
      else if (c == 15) check("pause_timeout", 9'h100, 1'b0, 1'b1);
      else              check("pause_done", 9'h100, 1'b0, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("pause_ack", 9'h000, 1'b0, 1'b0);

    // Start on the expiring tick of 01 reloads with no timeout
    cyc(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("tick_race_pre", 9'h101, 1'b1, 1'b0);
    end
    cyc(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    check("tick_race_reload", 9'h107, 1'b1, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("tick_race_post", 9'h107, 1'b1, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("tick_race_cancel", 9'h000, 1'b0, 1'b0);

    // Reset mid-RUN at count 05: reset outputs next cycle, no timeout afterwards
    cyc(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_pre", 9'h105, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_mid_run", 9'h000, 1'b0, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("rst_after", 9'h000, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
